// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and write-source priority encoding for regfile_mp
package regfile_pkg;
  localparam int ZERO_REG = 0;
  localparam int LINK_REG_DEF = 31;
  typedef enum logic [1:0] {WSRC_NONE, WSRC_A, WSRC_B, WSRC_LINK} wsrc_t;
  function automatic wsrc_t wsrc_pick(input logic link_hit, input logic b_hit, input logic a_hit);
    return link_hit ? WSRC_LINK : b_hit ? WSRC_B : a_hit ? WSRC_A : WSRC_NONE;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set/clear, two queries and clear-bypass
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_busy1,
  output logic          q_busy2
);
  logic [NREG-1:0] busy, busy_nxt;
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk) busy <= rst ? '0 : busy_nxt;
  always_comb begin
    q_busy1 = busy[q_addr1] && !(BYPASS != 0 && clr_en && clr_addr == q_addr1 && !(set_en && set_addr == q_addr1));
    q_busy2 = busy[q_addr2] && !(BYPASS != 0 && clr_en && clr_addr == q_addr2 && !(set_en && set_addr == q_addr2));
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with link write path, write-to-read bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int LINK_REG = NREG - 1,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          rd_busy1,
  output logic          rd_busy2,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          link_en,
  input  logic [DW-1:0] link_data,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr
);
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] wdata [NREG];
  wsrc_t src [NREG];
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      src[i] = i == ZERO_REG ? WSRC_NONE :
               wsrc_pick(link_en && i == LINK_REG, wb_en && wb_addr == AW'(i), wa_en && wa_addr == AW'(i));
      wdata[i] = src[i] == WSRC_LINK ? link_data : src[i] == WSRC_B ? wb_data : wa_data;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs[i] <= '0;
      else if (src[i] != WSRC_NONE) regs[i] <= wdata[i];
    end
  end
  always_comb begin
    rd_data1 = rd_addr1 == AW'(ZERO_REG) ? '0 :
               (BYPASS != 0 && !rst && src[rd_addr1] != WSRC_NONE) ? wdata[rd_addr1] : regs[rd_addr1];
    rd_data2 = rd_addr2 == AW'(ZERO_REG) ? '0 :
               (BYPASS != 0 && !rst && src[rd_addr2] != WSRC_NONE) ? wdata[rd_addr2] : regs[rd_addr2];
  end
  regfile_scoreboard #(.NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(busy_set),
    .set_addr(busy_addr),
    .clr_en(wb_en),
    .clr_addr(wb_addr),
    .q_addr1(rd_addr1),
    .q_addr2(rd_addr2),
    .q_busy1(rd_busy1),
    .q_busy2(rd_busy2)
  );
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Next-generation register file for the MIPS datapath, parametrised in data width and register count.
- Two combinational read ports and two write ports: port A for ALU writeback, port B for late/load writeback.
- Adds a dedicated link-register write path, optional write-to-read bypass, and a per-register busy scoreboard for multicycle producers.
- Sits between decode (reads, busy query) and the writeback stages.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers; must be a power of two, at least 4.
- AW, $clog2(NREG), register address width (derived; not overridden).
- LINK_REG, NREG-1, index written by the link path.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr1  in  AW  read port 1 address.
- rd_addr2  in  AW  read port 2 address.
- rd_data1  out  DW  read port 1 data (combinational).
- rd_data2  out  DW  read port 2 data (combinational).
- rd_busy1  out  1  register at rd_addr1 has a pending producer.
- rd_busy2  out  1  register at rd_addr2 has a pending producer.
- wa_en  in  1  write port A enable.
- wa_addr  in  AW  write port A address.
- wa_data  in  DW  write port A data.
- wb_en  in  1  write port B enable; also clears the busy bit of wb_addr.
- wb_addr  in  AW  write port B address.
- wb_data  in  DW  write port B data.
- link_en  in  1  write link_data to LINK_REG.
- link_data  in  DW  return address (PC+4).
- busy_set  in  1  mark busy_addr busy (load/multicycle op issued).
- busy_addr  in  AW  register to mark busy.

Behaviour:
- Reset: while rst is high at a rising edge, all NREG registers become 0 and all busy bits become 0. All writes and busy_set in that cycle are ignored.
- After reset: every rd_data reads 0 and every rd_busy reads 0.
- Register 0:
  - always reads 0 and is never busy;
  - writes to it and busy_set on it are discarded;
  - a link write with LINK_REG=0 is also discarded.
- Writes commit on the rising edge after they are presented (1-cycle write latency).
- Write priority for one address in the same cycle: link > port B > port A. Exactly one value is committed; the lower-priority writes are dropped.
- Writes to different addresses in the same cycle all commit.
- Reads are combinational from rd_addr.
- BYPASS=1:
  - if an enabled write targets the read address this cycle, rd_data returns the highest-priority write data, not the stored value;
  - for address 0 it still returns 0;
  - no bypass while rst is high.
- BYPASS=0: rd_data always returns the stored value; the new value is visible the cycle after the edge.
- Scoreboard:
  - busy[busy_addr] is set at the edge when busy_set=1;
  - busy[wb_addr] is cleared at the edge when wb_en=1;
  - link writes and port A writes never change busy bits.
- Scoreboard collisions:
  - busy_set and wb_en on the same address in the same cycle: set wins (new producer), and the register still takes wb_data.
  - Port A write to a busy register: data commits and the busy bit stays set (WAW hazards are prevented upstream; the block does not check them).
- rd_busy:
  - equals the stored busy bit;
  - with BYPASS=1, it reads 0 if wb_en clears that address this cycle, unless busy_set targets the same address in the same cycle.
- All address widths are exact, so no out-of-range indices exist.

Decomposition:
- Shared package regfile_pkg:
  - ZERO_REG = 0 and default LINK_REG = 31;
  - write-source priority encoding (WSRC_NONE, WSRC_A, WSRC_B, WSRC_LINK) used by the storage and bypass logic.
- One sub-module, regfile_scoreboard: an NREG-bit busy vector with set/clear/reset, two query ports and clear-bypass.
- Storage, priority mux and bypass stay in regfile_mp.

Test Plan:
- Reset then read all addresses -> rd_data=0 and rd_busy=0 everywhere; wa_en with wa_addr=5, wa_data=0xDEADBEEF while rst=1 -> r5 still reads 0 after rst deasserts.
- wa_en write r0=0x1234 and wb_en write r7=0xA5A5A5A5 in the same cycle -> r0 reads 0; r7 reads 0xA5A5A5A5 the next cycle; with BYPASS=1, rd_addr1=7 shows 0xA5A5A5A5 during the write cycle.
- Same cycle: link_en with link_data=0x00400008, wb_en to r31 with 0x11, wa_en to r31 with 0x22 -> r31=0x00400008; then wb_en r31=0x11 alone -> r31=0x11.
- busy_set r9, then two idle cycles -> rd_busy1(addr 9)=1; then wb_en r9=0x55 -> during that cycle rd_busy1=0 (BYPASS=1) and rd_data1=0x55; next cycle busy=0 and r9=0x55.
- busy_set and wb_en both on r12 in the same cycle, wb_data=0x77 -> r12=0x77 and busy[12]=1 after the edge.
- BYPASS=0 build: wa_en r3=0x99 -> rd_data reads the old value in the write cycle and 0x99 the following cycle; rst mid-sequence with busy r4 set -> busy and registers cleared at that edge.
